// File: rtl/key_scan.sv
// 4x4 keypad scanner: one-cold column drive, row sync, frame debounce, single-key accept.
// Optional KEY_REPEAT_EN adds auto-repeat strobes while a single key stays held.
module key_scan #(
  parameter int unsigned C_SCAN_NUM        = 100000,
  parameter int unsigned C_DEBOUNCE_FRAMES = 3,
  parameter int unsigned C_REPEAT_FRAMES   = 25
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic [3:0] I_row,
  output logic [3:0] O_col,
  output logic [3:0] O_key,
  output logic       O_valid,
  output logic       O_pressed
);

  localparam int unsigned CNT_W = (C_SCAN_NUM > 1) ? $clog2(C_SCAN_NUM) : 1;
  localparam int unsigned STB_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_SCAN_NUM - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(C_DEBOUNCE_FRAMES - 1);

  if (C_SCAN_NUM < 4 || C_DEBOUNCE_FRAMES < 1 || C_DEBOUNCE_FRAMES > 15 || C_REPEAT_FRAMES < 1)
  begin : g_param_err
    $error("key_scan: parameter out of range");
  end

  logic [3:0]       row_meta, row_sync;
  logic [CNT_W-1:0] scan_cnt, scan_cnt_nx;
  logic [1:0]       col_idx, col_idx_nx;
  logic [3:0]       col_nx;
  logic [15:0]      raw, raw_nx, prev, prev_nx, deb, deb_nx;
  logic [STB_W-1:0] stable, stable_nx;
  logic [3:0]       key_nx;
  logic             valid_nx, pressed_nx;
  logic             sample_c, frame_end_c, deb_load_c, onehot_c, accept_c;
  logic [3:0]       code_c;

`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_W = $clog2(C_REPEAT_FRAMES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(C_REPEAT_FRAMES - 1);
  logic [REP_W-1:0] rep_cnt, rep_cnt_nx;
  logic             deb_onehot_c, rep_fire_c;
`endif

  // Next-state: scan rotation, frame capture, debounce and accept decision
  always_comb begin
    scan_cnt_nx = scan_cnt + CNT_W'(1);
    col_idx_nx  = col_idx;
    col_nx      = O_col;
    raw_nx      = raw;
    prev_nx     = prev;
    deb_nx      = deb;
    stable_nx   = stable;
    key_nx      = O_key;
    pressed_nx  = O_pressed;
    code_c      = 4'd0;

    sample_c    = (scan_cnt == CNT_LAST);
    frame_end_c = sample_c && (col_idx == 2'd3);

    if (sample_c) begin
      raw_nx[{col_idx, 2'b00} +: 4] = ~row_sync;
      scan_cnt_nx = '0;
      col_idx_nx  = col_idx + 2'd1;
      col_nx      = {O_col[2:0], O_col[3]};
    end

    if (frame_end_c) begin
      if (raw_nx == prev)
        stable_nx = (stable == STB_LAST) ? stable : stable + STB_W'(1);
      else
        stable_nx = '0;
      prev_nx = raw_nx;
    end

    deb_load_c = frame_end_c && (stable_nx == STB_LAST);
    onehot_c   = (raw_nx != 16'd0) && ((raw_nx & (raw_nx - 16'd1)) == 16'd0);
    accept_c   = deb_load_c && (deb == 16'd0) && onehot_c;

    // Bit index is col*4+row; the code is {row, col}
    for (int i = 0; i < 16; i++)
      if (raw_nx[i]) code_c = {2'(i % 4), 2'(i / 4)};

    if (deb_load_c) begin
      deb_nx     = raw_nx;
      pressed_nx = (raw_nx != 16'd0);
    end
    if (accept_c) key_nx = code_c;

    valid_nx = accept_c;

`ifdef KEY_REPEAT_EN
    rep_cnt_nx   = rep_cnt;
    rep_fire_c   = 1'b0;
    deb_onehot_c = (deb != 16'd0) && ((deb & (deb - 16'd1)) == 16'd0);
    if (accept_c) begin
      rep_cnt_nx = '0;
    end else if (frame_end_c) begin
      if (deb_nx != deb) begin
        rep_cnt_nx = '0;
      end else if (deb_onehot_c) begin
        if (rep_cnt == REP_LAST) begin
          rep_fire_c = 1'b1;
          rep_cnt_nx = '0;
        end else begin
          rep_cnt_nx = rep_cnt + REP_W'(1);
        end
      end
    end
    valid_nx = accept_c | rep_fire_c;
`endif
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      row_meta  <= 4'b1111;
      row_sync  <= 4'b1111;
      scan_cnt  <= '0;
      col_idx   <= 2'd0;
      O_col     <= 4'b1110;
      raw       <= 16'h0000;
      prev      <= 16'h0000;
      deb       <= 16'h0000;
      stable    <= '0;
      O_key     <= 4'd0;
      O_valid   <= 1'b0;
      O_pressed <= 1'b0;
    end else begin
      row_meta  <= I_row;
      row_sync  <= row_meta;
      scan_cnt  <= scan_cnt_nx;
      col_idx   <= col_idx_nx;
      O_col     <= col_nx;
      raw       <= raw_nx;
      prev      <= prev_nx;
      deb       <= deb_nx;
      stable    <= stable_nx;
      O_key     <= key_nx;
      O_valid   <= valid_nx;
      O_pressed <= pressed_nx;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) rep_cnt <= '0;
    else          rep_cnt <= rep_cnt_nx;
  end
`endif

endmodule

// File: doc/key_scan.md
Name: key_scan

Overview:
- 4x4 matrix keypad scanner with debouncer for the sprint timer front panel.
- It is the input-side counterpart of the multiplexed 7-segment display driver: it drives one-cold column selects round-robin, reads the row lines, and emits a debounced 4-bit key code with a one-cycle valid strobe.
- The codes feed the timer control FSM (start/stop/reset/digit entry).

Parameters:
- C_SCAN_NUM, 100000: I_clk cycles each column is held driven. Must be >= 4.
- C_DEBOUNCE_FRAMES, 3: consecutive identical full scan frames required before the debounced state updates. Range 1..15.
- C_REPEAT_FRAMES, 25: frames a single key must stay held before auto-repeat strobes. Used only with KEY_REPEAT_EN.

Ports:
- I_clk  input  1  system clock
- I_rst_n  input  1  reset; asynchronous, active-low
- I_row  input  4  keypad row lines, active-low (external pull-ups), asynchronous to I_clk
- O_col  output  4  column drive, one-cold active-low
- O_key  output  4  last accepted key code; code = {row_index[1:0], col_index[1:0]}
- O_valid  output  1  one-cycle strobe; O_key is updated in the same cycle
- O_pressed  output  1  level; high while the debounced frame has any key down

Behaviour:
- Reset values (asynchronous): O_col=4'b1110, scan counter=0, column index=0, row synchronizer=4'b1111, raw/previous/debounced frames=16'h0000, stable count=0, O_key=0, O_valid=0, O_pressed=0.
- Row input: 2-flop synchronizer on I_row. After the synchronizer, rows are inverted so that 1 means pressed.
- Scan counter: runs 0..C_SCAN_NUM-1 per column. At count C_SCAN_NUM-1:
  - the synchronized rows are stored into raw frame bits [col*4 +: 4];
  - the counter clears;
  - the column index advances 0->1->2->3->0, and O_col rotates 1110->1101->1011->0111->1110.
- Frame period: one frame is 4*C_SCAN_NUM cycles. Frame end is the sample cycle of column 3.
- Debounce, evaluated at frame end, using the newly completed raw frame (including the column 3 bits just captured):
  - If raw equals the previous raw frame, the stable count increments, saturating at C_DEBOUNCE_FRAMES-1. Otherwise the stable count clears.
  - The previous raw frame is then loaded with the new raw frame.
  - When stable count == C_DEBOUNCE_FRAMES-1 (including the frame that reached it), the debounced frame is loaded with raw.
- Accept rule: when the debounced frame is updated, the old debounced frame was 0, and the new frame has exactly one bit set:
  - O_key <= {row, col} of that bit;
  - O_valid = 1 for exactly one cycle (the cycle after the frame-end edge).
- No-accept cases:
  - Multiple simultaneous keys (popcount >= 2): no strobe, O_key holds.
  - Additional key pressed while one is held (old debounced frame nonzero): no strobe.
  - Release to 0 is required before the next accept.
- O_pressed is registered, equal to (debounced frame != 0), and updates with the debounced frame.
- Glitch shorter than one frame (bounce): breaks stability and clears the count. The debounced frame is unchanged until C_DEBOUNCE_FRAMES identical frames have been seen.
- C_DEBOUNCE_FRAMES=1: the debounced frame follows raw every frame.
- Reset mid-scan: all state returns to reset values immediately. Scanning restarts at column 0 with count 0. A pending strobe is lost.
- Latency: press (stable from before a frame start) to O_valid = C_DEBOUNCE_FRAMES+1 frames worst case, plus 3 cycles.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - A repeat counter clears on each accept and increments at every frame end while the debounced frame is unchanged and has exactly one bit set.
  - On reaching C_REPEAT_FRAMES, O_valid pulses again with the same O_key, and the counter clears (a repeat every C_REPEAT_FRAMES frames).
  - Any change of the debounced frame clears the counter.
- Undefined: no repeat logic. Exactly one strobe per press.

Test Plan (C_SCAN_NUM=10, C_DEBOUNCE_FRAMES=3, frame = 40 cycles):
- Reset, then idle rows 4'b1111 for 200 cycles -> O_col cycles 1110/1101/1011/0111 every 10 cycles; O_valid never asserts; O_pressed=0.
- Model shorts row 2 to column 1, held 200 cycles -> exactly one O_valid pulse, O_key=4'b1001, O_pressed=1. Release -> O_pressed=0 after 3 stable frames; no strobe on release.
- Key row 0/col 3 bounces (toggles every 7 cycles for 100 cycles), then holds steady -> no strobe during bounce; exactly one strobe with O_key=4'b0011 after 3 clean frames.
- Keys 0 and 5 pressed together -> no strobe, O_pressed=1. Release 5 while still holding 0 -> still no strobe; full release then press 5 -> strobe with O_key=4'b0101.
- Assert I_rst_n=0 mid-column-2 while a key is debouncing -> O_col=1110 and all outputs 0 immediately; after release, a full debounce is required before any strobe.
- With KEY_REPEAT_EN and C_REPEAT_FRAMES=4, hold key 7 for 20 frames -> first strobe, then a strobe every 4 frames, all with O_key=4'b0111.
